multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencing controller for the LEGv8 datapath. Replaces the single-cycle main decoder when the CPU shares one memory port and one ALU across several cycles per instruction.
- Walks each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux and enable.
- Handshakes with memory (mem_ready) and aborts stalled memory accesses through a timeout counter.

Parameters:
- WAIT_MAX, 16, maximum cycles a memory state waits for mem_ready before aborting (must be at least 2).
- CW, $clog2(WAIT_MAX+1), width of the wait counter (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- insOp  in  11  opcode field [31:21] of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  writeback select: 1 = MDR.
- Reg2Loc  out  1  register read port 2 select: 1 = Rt.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended address, 11 = branch offset shifted left 2.
- ALUOp  out  2  00 = add, 01 = pass B, 10 = R-type funct.
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- instr_done  out  1  one-cycle pulse at instruction retirement.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- mem_err  out  1  one-cycle pulse on a memory timeout.
- state_o  out  4  current state encoding (debug).

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, RWB=3, ADDR=4, MRD=5, LWB=6, MWR=7, BR=8. Encodings 9 to 15 are unreachable and return to FETCH.
- Reset: on a rising edge with rst=1, state becomes FETCH, the wait counter clears and the class latches clear. While rst=1, every output is forced to 0, including state_o.
- Opcode classes, latched in DECODE:
  - R-type: 1xx0101x000.
  - LDUR: 11111000010.
  - STUR: 11111000000.
  - CBZ: 10110100xxx.
  - B: 000101xxxxx.
  - Any other opcode: illegal.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - On mem_ready=1: IRWrite=1 and PCWrite=1 in the same cycle (Mealy), next state DECODE.
  - Otherwise: stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes branch target into ALUOut). Reg2Loc=1 if insOp is STUR or CBZ.
  - Next state: R-type→EXEC; LDUR/STUR→ADDR; CBZ/B→BR; illegal→FETCH with illegal=1 for one cycle and no other side effects.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, Reg2Loc=0. Next state RWB.
- RWB: RegWrite=1, MemtoReg=0, instr_done=1. Next state FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 for STUR. Next state MRD for LDUR, MWR for STUR.
- MRD: IorD=1, MemRead=1 held until mem_ready=1. Next state LWB.
- LWB: RegWrite=1, MemtoReg=1, instr_done=1. Next state FETCH.
- MWR: IorD=1, MemWrite=1, Reg2Loc=1, held until mem_ready. On mem_ready=1: instr_done=1, next state FETCH.
- BR: PCSource=1. Next state FETCH; instr_done=1.
  - CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCWrite=zero.
  - B: PCWrite=1 unconditionally.
- Any output not listed for a state is 0.
- Wait counter:
  - Clears on entry to FETCH, MRD or MWR.
  - Increments on each cycle in those states with mem_ready=0.
  - If the counter equals WAIT_MAX-1 and mem_ready=0: pulse mem_err, go to FETCH, and suppress IRWrite, PCWrite, RegWrite and a retry of the write.
  - mem_ready=1 on the timeout cycle wins: the access completes normally with no mem_err.
- Latency: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3, each with zero wait states.
- insOp changes after FETCH do not affect the latched class.

Decomposition:
- Shared package lg8_ctrl_pkg:
  - State enum and encodings.
  - Opcode match patterns for R-type, LDUR, STUR, CBZ and B.
  - ALUSrcB and ALUOp constants.
- One sub-module, opcode_class_decode: combinational, insOp → one-hot class {r, ldur, stur, cbz, b, illegal}. Reusable by the single-cycle decoder.

Test Plan:
- Reset, then rst=0 and mem_ready=1 on the first FETCH cycle → IRWrite=1, PCWrite=1 in that cycle; state_o=1 on the next cycle. While rst=1, every output is 0.
- ADD (insOp=10001011000), mem_ready=1 always → state_o sequence 0,1,2,3,0; RegWrite=1 only in state 3; ALUOp=10 in state 2; instr_done after 4 cycles.
- LDUR (11111000010) with mem_ready low for 3 cycles in MRD → MemRead and IorD held for 4 cycles; then LWB with MemtoReg=1 and RegWrite=1; total 8 cycles.
- CBZ (10110100101): with zero=1, PCWrite=1 and PCSource=1 in BR; with zero=0, PCWrite=0. B (00010100000): PCWrite=1 regardless of zero.
- STUR with mem_ready held 0, WAIT_MAX=16 → MemWrite high for exactly 16 cycles, mem_err=1 on the 16th, next state FETCH, no instr_done. Repeat with mem_ready=1 on the 16th cycle → completes with no mem_err.
- insOp=00000000000 → illegal pulse in DECODE, return to FETCH, no RegWrite or MemWrite. Also assert rst mid-MRD → FETCH on the next edge with MemRead=0 during rst.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the LEGv8 control path: state encodings,
// opcode match patterns and ALU select constants.
package lg8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_RWB    = 4'd3,
    S_ADDR   = 4'd4,
    S_MRD    = 4'd5,
    S_LWB    = 4'd6,
    S_MWR    = 4'd7,
    S_BR     = 4'd8
  } state_t;

  typedef struct packed {
    logic r;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } opClass_t;

  // Opcode patterns as mask/value pairs over insOp[10:0]; a mask bit of 0
  // marks a don't-care position.
  localparam logic [10:0] R_MASK    = 11'b10011110111;
  localparam logic [10:0] R_VAL     = 11'b10001010000;
  localparam logic [10:0] LDUR_MASK = 11'b11111111111;
  localparam logic [10:0] LDUR_VAL  = 11'b11111000010;
  localparam logic [10:0] STUR_MASK = 11'b11111111111;
  localparam logic [10:0] STUR_VAL  = 11'b11111000000;
  localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [10:0] CBZ_VAL   = 11'b10110100000;
  localparam logic [10:0] B_MASK    = 11'b11111100000;
  localparam logic [10:0] B_VAL     = 11'b00010100000;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_ADDR  = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  function automatic logic opMatch(input logic [10:0] op,
                                   input logic [10:0] mask,
                                   input logic [10:0] val);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing signal bundle of the multi-cycle controller.
interface multicycle_controller_if;
  logic [10:0] insOp;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        IRWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        Reg2Loc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        PCSource;
  logic        instr_done;
  logic        illegal;
  logic        mem_err;
  logic [3:0]  state_o;

  modport slave (
    input  insOp, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
           Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal,
           mem_err, state_o
  );

  modport master (
    output insOp, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
           Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal,
           mem_err, state_o
  );
endinterface

// File: rtl/multicycle_controller_opcode_class_decode.sv
// Combinational opcode classifier: insOp -> one-hot instruction class.
module opcode_class_decode
  import lg8_ctrl_pkg::*;
(
  input  logic [10:0] insOp,
  output opClass_t    opClass
);

  // Exact-match opcodes first so they never alias into a wider pattern.
  always_comb begin
    opClass = '0;
    if (opMatch(insOp, LDUR_MASK, LDUR_VAL))      opClass.ldur    = 1'b1;
    else if (opMatch(insOp, STUR_MASK, STUR_VAL)) opClass.stur    = 1'b1;
    else if (opMatch(insOp, R_MASK, R_VAL))       opClass.r       = 1'b1;
    else if (opMatch(insOp, CBZ_MASK, CBZ_VAL))   opClass.cbz     = 1'b1;
    else if (opMatch(insOp, B_MASK, B_VAL))       opClass.b       = 1'b1;
    else                                          opClass.illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 sequencing controller with memory-wait timeout.
//   state  | meaning
//   FETCH  | read instruction at PC, PC += 4 on mem_ready
//   DECODE | classify opcode, precompute branch target into ALUOut
//   EXEC   | R-type ALU operation
//   RWB    | R-type register writeback, retire
//   ADDR   | load/store effective address
//   MRD    | data memory read, wait for mem_ready
//   LWB    | load writeback from MDR, retire
//   MWR    | data memory write, wait for mem_ready, retire
//   BR     | CBZ / B PC update, retire
module multicycle_controller
  import lg8_ctrl_pkg::*;
#(
  parameter  int WAIT_MAX = 16,
  localparam int CW       = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.slave bus
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt;
  opClass_t      decClass;
  logic          latLdur, latStur, latCbz;
  logic          inWait, timeout;

  logic       pcWrite, irWrite, iorD, memRead, memWrite, regWrite, memtoReg;
  logic       reg2Loc, aluSrcA, pcSource, instrDone, illegalP, memErr;
  logic [1:0] aluSrcB, aluOp;

  opcode_class_decode uDecode (
    .insOp   (bus.insOp),
    .opClass (decClass)
  );

  assign inWait  = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
  assign timeout = inWait && !bus.mem_ready && (waitCnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= stateNext;
  end

  // Wait counter: restarts whenever a wait state is (re)entered, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)                                  waitCnt <= '0;
    else if ((stateNext != state) || timeout) waitCnt <= '0;
    else if (inWait && !bus.mem_ready)        waitCnt <= waitCnt + CW'(1);
  end

  // Instruction class is captured in DECODE so later insOp changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      latLdur <= 1'b0;
      latStur <= 1'b0;
      latCbz  <= 1'b0;
    end else if (state == S_DECODE) begin
      latLdur <= decClass.ldur;
      latStur <= decClass.stur;
      latCbz  <= decClass.cbz;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    stateNext = S_FETCH;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    memtoReg  = 1'b0;
    reg2Loc   = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    aluOp     = ALUOP_ADD;
    pcSource  = 1'b0;
    instrDone = 1'b0;
    illegalP  = 1'b0;
    memErr    = 1'b0;
    case (state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (bus.mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = S_DECODE;
        end else begin
          memErr    = timeout;
          stateNext = S_FETCH;
        end
      end
      S_DECODE: begin
        aluSrcB  = SRCB_BROFF;
        reg2Loc  = decClass.stur | decClass.cbz;
        illegalP = decClass.illegal;
        if (decClass.r)                       stateNext = S_EXEC;
        else if (decClass.ldur | decClass.stur) stateNext = S_ADDR;
        else if (decClass.cbz | decClass.b)   stateNext = S_BR;
      end
      S_EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = ALUOP_RTYPE;
        stateNext = S_RWB;
      end
      S_RWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_ADDR;
        reg2Loc = latStur;
        if (latStur)      stateNext = S_MWR;
        else if (latLdur) stateNext = S_MRD;
      end
      S_MRD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
        if (bus.mem_ready)  stateNext = S_LWB;
        else if (timeout)   memErr    = 1'b1;
        else                stateNext = S_MRD;
      end
      S_LWB: begin
        regWrite  = 1'b1;
        memtoReg  = 1'b1;
        instrDone = 1'b1;
      end
      S_MWR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        reg2Loc  = 1'b1;
        if (bus.mem_ready) instrDone = 1'b1;
        else if (timeout)  memErr    = 1'b1;
        else               stateNext = S_MWR;
      end
      S_BR: begin
        pcSource  = 1'b1;
        instrDone = 1'b1;
        if (latCbz) begin
          aluSrcA = 1'b1;
          aluOp   = ALUOP_PASSB;
          reg2Loc = 1'b1;
          pcWrite = bus.zero;
        end else begin
          pcWrite = 1'b1;
        end
      end
      default: stateNext = S_FETCH;
    endcase
  end

  // Every output is held low while reset is asserted.
  assign bus.PCWrite    = pcWrite   & ~rst;
  assign bus.IRWrite    = irWrite   & ~rst;
  assign bus.IorD       = iorD      & ~rst;
  assign bus.MemRead    = memRead   & ~rst;
  assign bus.MemWrite   = memWrite  & ~rst;
  assign bus.RegWrite   = regWrite  & ~rst;
  assign bus.MemtoReg   = memtoReg  & ~rst;
  assign bus.Reg2Loc    = reg2Loc   & ~rst;
  assign bus.ALUSrcA    = aluSrcA   & ~rst;
  assign bus.ALUSrcB    = rst ? 2'b00 : aluSrcB;
  assign bus.ALUOp      = rst ? 2'b00 : aluOp;
  assign bus.PCSource   = pcSource  & ~rst;
  assign bus.instr_done = instrDone & ~rst;
  assign bus.illegal    = illegalP  & ~rst;
  assign bus.mem_err    = memErr    & ~rst;
  assign bus.state_o    = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams checked against a per-instruction event model.
module tb_multicycle_controller;

  localparam int WAIT_MAX = 16;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [20:0] allOut = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead,
                        bus.MemWrite, bus.RegWrite, bus.MemtoReg, bus.Reg2Loc,
                        bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                        bus.instr_done, bus.illegal, bus.mem_err, bus.state_o};

  initial begin
    bus.insOp     = OP_ADD;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
  end

  // Drive one cycle of inputs mid-period and let outputs settle before sampling.
  task automatic step(input logic [10:0] op, input logic z, input logic mr,
                      input logic r);
    @(negedge clk);
    rst           = r;
    bus.insOp     = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(OP_ADD, 1'b1, 1'b1, 1'b1);
      checks++;
      if (allOut !== 21'd0) begin
        errors++;
        $display("FAIL reset_outputs_zero: got %h want 0", allOut);
      end
    end
    step(OP_ADD, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.IRWrite, bus.PCWrite, bus.MemRead, bus.IorD, bus.ALUSrcA,
         bus.ALUSrcB, bus.ALUOp, bus.state_o} !== {1'b1, 1'b1, 1'b1, 1'b0,
         1'b0, 2'b01, 2'b00, 4'd0}) begin
      errors++;
      $display("FAIL first_fetch: got IRW=%b PCW=%b MR=%b IorD=%b A=%b B=%b op=%b st=%0d want 1 1 1 0 0 01 00 0",
               bus.IRWrite, bus.PCWrite, bus.MemRead, bus.IorD, bus.ALUSrcA,
               bus.ALUSrcB, bus.ALUOp, bus.state_o);
    end
    step(OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.state_o, bus.ALUSrcB, bus.ALUSrcA} !== {4'd1, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL decode_after_fetch: got st=%0d B=%b A=%b want 1 11 0",
               bus.state_o, bus.ALUSrcB, bus.ALUSrcA);
    end
  endtask

  task automatic test_rtype;
    int expSt [4] = '{0, 1, 2, 3};
    step(OP_ADD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(OP_ADD, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.state_o !== 4'(expSt[i]) || bus.RegWrite !== (i == 3) ||
          bus.instr_done !== (i == 3)) begin
        errors++;
        $display("FAIL rtype_cycle%0d: got st=%0d RW=%b done=%b want st=%0d RW=%b done=%b",
                 i, bus.state_o, bus.RegWrite, bus.instr_done, expSt[i],
                 (i == 3), (i == 3));
      end
      if (i == 2) begin
        checks++;
        if (bus.ALUOp !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin
          errors++;
          $display("FAIL rtype_exec_alu: got op=%b A=%b B=%b want 10 1 00",
                   bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB);
        end
      end
    end
    step(OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd0) begin
      errors++;
      $display("FAIL rtype_return: got st=%0d want 0", bus.state_o);
    end
  endtask

  task automatic test_ldur_wait;
    int   expSt [8] = '{0, 1, 4, 5, 5, 5, 5, 6};
    logic mrSeq [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   rdHeld = 0;
    step(OP_LDUR, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(OP_LDUR, 1'b0, mrSeq[i], 1'b0);
      checks++;
      if (bus.state_o !== 4'(expSt[i])) begin
        errors++;
        $display("FAIL ldur_state_cycle%0d: got %0d want %0d", i, bus.state_o, expSt[i]);
      end
      if (bus.MemRead && bus.IorD) rdHeld++;
      if (i == 2) begin
        checks++;
        if (bus.ALUSrcB !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.Reg2Loc !== 1'b0) begin
          errors++;
          $display("FAIL ldur_addr: got B=%b A=%b R2L=%b want 10 1 0",
                   bus.ALUSrcB, bus.ALUSrcA, bus.Reg2Loc);
        end
      end
      if (i == 7) begin
        checks++;
        if ({bus.MemtoReg, bus.RegWrite, bus.instr_done} !== 3'b111) begin
          errors++;
          $display("FAIL ldur_lwb: got MtoR/RW/done=%b want 111",
                   {bus.MemtoReg, bus.RegWrite, bus.instr_done});
        end
      end
    end
    checks++;
    if (rdHeld != 4) begin
      errors++;
      $display("FAIL ldur_mrd_hold: got %0d cycles want 4", rdHeld);
    end
    step(OP_LDUR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd0) begin
      errors++;
      $display("FAIL ldur_return: got st=%0d want 0", bus.state_o);
    end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 4; k++) begin
      logic [10:0] op = (k < 2) ? OP_CBZ : OP_B;
      logic        z  = k[0];
      logic        expPcw = (k < 2) ? z : 1'b1;
      step(op, z, 1'b0, 1'b1);
      step(op, z, 1'b1, 1'b0);
      step(op, z, 1'b0, 1'b0);
      checks++;
      if (bus.Reg2Loc !== (k < 2)) begin
        errors++;
        $display("FAIL branch%0d_decode_reg2loc: got %b want %b", k, bus.Reg2Loc, (k < 2));
      end
      step(8'hA5 ^ op, z, 1'b0, 1'b0);
      checks++;
      if ({bus.state_o, bus.PCSource, bus.PCWrite, bus.instr_done} !==
          {4'd8, 1'b1, expPcw, 1'b1}) begin
        errors++;
        $display("FAIL branch%0d_br: got st=%0d PCS=%b PCW=%b done=%b want 8 1 %b 1",
                 k, bus.state_o, bus.PCSource, bus.PCWrite, bus.instr_done, expPcw);
      end
      if (k < 2) begin
        checks++;
        if (bus.ALUOp !== 2'b01 || bus.ALUSrcA !== 1'b1 || bus.Reg2Loc !== 1'b1) begin
          errors++;
          $display("FAIL cbz%0d_alu: got op=%b A=%b R2L=%b want 01 1 1",
                   k, bus.ALUOp, bus.ALUSrcA, bus.Reg2Loc);
        end
      end
    end
  endtask

  task automatic test_stur_timeout;
    for (int lastReady = 0; lastReady < 2; lastReady++) begin
      int wrCycles = 0;
      step(OP_STUR, 1'b0, 1'b0, 1'b1);
      step(OP_STUR, 1'b0, 1'b1, 1'b0);
      step(OP_STUR, 1'b0, 1'b0, 1'b0);
      step(OP_STUR, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.state_o, bus.ALUSrcB, bus.Reg2Loc} !== {4'd4, 2'b10, 1'b1}) begin
        errors++;
        $display("FAIL stur_addr: got st=%0d B=%b R2L=%b want 4 10 1",
                 bus.state_o, bus.ALUSrcB, bus.Reg2Loc);
      end
      for (int i = 0; i < WAIT_MAX; i++) begin
        logic mr     = (i == WAIT_MAX - 1) && (lastReady == 1);
        logic expErr = (i == WAIT_MAX - 1) && (lastReady == 0);
        step(OP_STUR, 1'b0, mr, 1'b0);
        if (bus.MemWrite) wrCycles++;
        checks++;
        if (bus.mem_err !== expErr || bus.instr_done !== mr) begin
          errors++;
          $display("FAIL stur_wait%0d_cycle%0d: got err=%b done=%b want %b %b",
                   lastReady, i, bus.mem_err, bus.instr_done, expErr, mr);
        end
      end
      checks++;
      if (wrCycles != WAIT_MAX) begin
        errors++;
        $display("FAIL stur_memwrite_len%0d: got %0d want %0d", lastReady, wrCycles, WAIT_MAX);
      end
      step(OP_STUR, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.state_o !== 4'd0 || bus.MemWrite !== 1'b0) begin
        errors++;
        $display("FAIL stur_return%0d: got st=%0d MW=%b want 0 0",
                 lastReady, bus.state_o, bus.MemWrite);
      end
    end
  endtask

  task automatic test_illegal;
    step(OP_ILL, 1'b0, 1'b0, 1'b1);
    step(OP_ILL, 1'b0, 1'b1, 1'b0);
    step(OP_ILL, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.illegal, bus.RegWrite, bus.MemWrite, bus.instr_done} !== 4'b1000) begin
      errors++;
      $display("FAIL illegal_decode: got ill/RW/MW/done=%b want 1000",
               {bus.illegal, bus.RegWrite, bus.MemWrite, bus.instr_done});
    end
    step(OP_ILL, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_return: got st=%0d ill=%b want 0 0", bus.state_o, bus.illegal);
    end
  endtask

  task automatic test_reset_mid_mrd;
    step(OP_LDUR, 1'b0, 1'b0, 1'b1);
    step(OP_LDUR, 1'b0, 1'b1, 1'b0);
    step(OP_LDUR, 1'b0, 1'b0, 1'b0);
    step(OP_LDUR, 1'b0, 1'b0, 1'b0);
    step(OP_LDUR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd5) begin
      errors++;
      $display("FAIL midmrd_reach: got st=%0d want 5", bus.state_o);
    end
    step(OP_LDUR, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.MemRead !== 1'b0 || allOut !== 21'd0) begin
      errors++;
      $display("FAIL midmrd_rst_outputs: got %h want 0", allOut);
    end
    step(OP_LDUR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd0 || bus.MemRead !== 1'b1 || bus.IorD !== 1'b0) begin
      errors++;
      $display("FAIL midmrd_after_rst: got st=%0d MR=%b IorD=%b want 0 1 0",
               bus.state_o, bus.MemRead, bus.IorD);
    end
  endtask

  function automatic int pickWait();
    int r = $urandom_range(0, 9);
    if (r == 0) return WAIT_MAX;
    if (r == 1) return WAIT_MAX - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic test_random;
    step(OP_ADD, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 60; t++) begin
      int          cls = $urandom_range(0, 5);
      int          wF = pickWait();
      int          wM = pickWait();
      logic        z = 1'($urandom_range(0, 1));
      logic [10:0] op;
      int          fetchLen, memLen, memStart, total;
      bit          isMem;
      int          eP = 0, eI = 0, eR = 0, eW = 0, eRW = 0, eD = 0, eIl = 0, eE = 0;
      int          oP = 0, oI = 0, oR = 0, oW = 0, oRW = 0, oD = 0, oIl = 0, oE = 0;
      case (cls)
        0:       op = OP_ADD | (11'($urandom) & 11'b01100001000);
        1:       op = OP_LDUR;
        2:       op = OP_STUR;
        3:       op = (OP_CBZ & 11'b11111111000) | 11'($urandom_range(0, 7));
        4:       op = OP_B | 11'($urandom_range(0, 31));
        default: op = $urandom_range(0, 1) ? 11'h000 : 11'h7FF;
      endcase
      isMem    = (cls == 1) || (cls == 2);
      fetchLen = (wF >= WAIT_MAX) ? WAIT_MAX : wF + 1;
      memLen   = (wM >= WAIT_MAX) ? WAIT_MAX : wM + 1;
      memStart = fetchLen + 2;
      eR       = fetchLen;
      total    = fetchLen;
      if (wF >= WAIT_MAX) begin
        eE = 1;
        isMem = 1'b0;
      end else begin
        eP = 1; eI = 1; total += 1;
        case (cls)
          0: begin total += 2; eRW = 1; eD = 1; end
          1: begin
            total += 1 + memLen; eR += memLen;
            if (wM < WAIT_MAX) begin total += 1; eRW = 1; eD = 1; end
            else eE = 1;
          end
          2: begin
            total += 1 + memLen; eW = memLen;
            if (wM < WAIT_MAX) eD = 1; else eE = 1;
          end
          3: begin total += 1; eP += int'(z); eD = 1; end
          4: begin total += 1; eP += 1; eD = 1; end
          default: eIl = 1;
        endcase
      end
      for (int c = 0; c < total; c++) begin
        logic [10:0] opC = (c <= fetchLen) ? op : 11'($urandom);
        logic        zC  = (c == fetchLen + 1) ? z : 1'($urandom_range(0, 1));
        logic        mrC;
        if (c < fetchLen)
          mrC = (c == wF);
        else if (isMem && c >= memStart && c < memStart + memLen)
          mrC = (c == memStart + wM);
        else
          mrC = 1'($urandom_range(0, 1));
        step(opC, zC, mrC, 1'b0);
        if (c == 0) begin
          checks++;
          if (bus.state_o !== 4'd0) begin
            errors++;
            $display("FAIL rand%0d_start_state: got %0d want 0", t, bus.state_o);
          end
        end
        oP += int'(bus.PCWrite);  oI += int'(bus.IRWrite);
        oR += int'(bus.MemRead);  oW += int'(bus.MemWrite);
        oRW += int'(bus.RegWrite); oD += int'(bus.instr_done);
        oIl += int'(bus.illegal); oE += int'(bus.mem_err);
      end
      checks++;
      if ({oP, oI, oR, oW, oRW, oD, oIl, oE} != {eP, eI, eR, eW, eRW, eD, eIl, eE}) begin
        errors++;
        $display("FAIL rand%0d_events cls=%0d wF=%0d wM=%0d z=%b: got pcw=%0d irw=%0d rd=%0d wr=%0d rw=%0d done=%0d ill=%0d err=%0d want %0d %0d %0d %0d %0d %0d %0d %0d",
                 t, cls, wF, wM, z, oP, oI, oR, oW, oRW, oD, oIl, oE,
                 eP, eI, eR, eW, eRW, eD, eIl, eE);
      end
    end
    step(OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_o !== 4'd0) begin
      errors++;
      $display("FAIL rand_final_state: got %0d want 0", bus.state_o);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldur_wait();
    test_branch();
    test_stur_timeout();
    test_illegal();
    test_reset_mid_mrd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
